// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode encodings, default XLEN and the fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd];
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) r_mem[r_wr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word at a time and buffers it for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign output.
module fetch_unit #(
    parameter int unsigned     XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      inst_opcode
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign
`endif
);

    import riscv_pkg::*;

    fetch_state_t      r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic [2*XLEN-1:0] r_hold;
    logic [2*XLEN-1:0] w_head;
    logic [2*XLEN-1:0] w_shown;
    logic [XLEN-1:0]   w_redirect_pc;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_req_fire;
    logic              w_block;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_block        = r_misalign;
    assign w_redirect_pc  = redirect_pc;
    assign fetch_misalign = r_misalign;

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end
`else
    assign w_block       = 1'b0;
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    // A pop this cycle counts as a free slot for issuing, never for the push.
    assign w_pop          = !w_empty && inst_ready;
    assign imem_req_valid = !rst && !w_block && (r_state == S_REQ) && (!w_full || w_pop);
    assign imem_req_addr  = {r_pc[XLEN-1:2], 2'b00};
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_push         = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // Empty FIFO keeps showing the last head; reset clears that copy to zero.
    assign w_shown     = w_empty ? r_hold : w_head;
    assign inst_valid  = !w_empty;
    assign inst_pc     = w_shown[2*XLEN-1:XLEN];
    assign inst_data   = w_shown[XLEN-1:0];
    assign inst_opcode = inst_data[6:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({r_req_pc, imem_rsp_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_hold   <= '0;
        end else begin
            if (!w_empty) r_hold <= w_head;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
                // Anything accepted now or still in flight must be drained before refetching.
                case (r_state)
                    S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
                    default: r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_req_fire) begin
                            r_req_pc <= r_pc;
                            r_pc     <= r_pc + XLEN'(4);
                            r_state  <= S_WAIT;
                        end
                    end
                    S_WAIT, S_DROP: begin
                        if (imem_rsp_valid) r_state <= S_REQ;
                    end
                    default: r_state <= S_REQ;
                endcase
            end
        end
    end

endmodule
